// File: rtl/alu_exec_unit.sv
// Handshaked 32-bit ALU with IDLE/SHIFT/DONE control.
// Define ALU_SERIAL_SHIFT_EN for a one-bit-per-cycle shifter; otherwise shifts use a barrel step.
module alu_exec_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] ALU_A,
    input  logic [31:0] ALU_B,
    input  logic [3:0]  ALUctr,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        zero,
    output logic        less
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t      state;
    state_t      state_nx;
    logic        accept;
    logic [4:0]  shamt_in;
    logic        is_shift_in;
    logic        less_in;
    logic [31:0] comb_res;
    logic        start_serial;
    logic        last_step;

    assign accept      = in_valid && in_ready;
    assign shamt_in    = ALU_B[4:0];
    assign is_shift_in = (ALUctr == 4'b0001) || (ALUctr == 4'b0101) || (ALUctr == 4'b1101);
    assign less_in     = (ALUctr == 4'b0011) ? (ALU_A < ALU_B)
                                             : ($signed(ALU_A) < $signed(ALU_B));

    always_comb begin
        comb_res = '0;
        case (ALUctr)
            4'b0000: comb_res = ALU_A + ALU_B;
            4'b1000: comb_res = ALU_A - ALU_B;
            4'b0001: comb_res = ALU_A << shamt_in;
            4'b0010: comb_res = {31'b0, less_in};
            4'b0011: comb_res = {31'b0, less_in};
            4'b0100: comb_res = ALU_A ^ ALU_B;
            4'b0101: comb_res = ALU_A >> shamt_in;
            4'b1101: comb_res = $unsigned($signed(ALU_A) >>> shamt_in);
            4'b0110: comb_res = ALU_A | ALU_B;
            4'b0111: comb_res = ALU_A & ALU_B;
            4'b1111: comb_res = ALU_B;
            default: comb_res = '0;
        endcase
    end

`ifdef ALU_SERIAL_SHIFT_EN
    logic [31:0] shreg;
    logic [31:0] shreg_nx;
    logic [4:0]  cnt;
    logic [3:0]  op_ctr;

    // Zero-amount shifts take the single-step path so latency stays 1.
    assign start_serial = accept && is_shift_in && (shamt_in != 5'd0);
    assign last_step    = (cnt == 5'd1);

    always_comb begin
        case (op_ctr)
            4'b0001: shreg_nx = {shreg[30:0], 1'b0};
            4'b0101: shreg_nx = {1'b0, shreg[31:1]};
            default: shreg_nx = {shreg[31], shreg[31:1]};
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg  <= '0;
            cnt    <= '0;
            op_ctr <= '0;
        end else if (start_serial) begin
            shreg  <= ALU_A;
            cnt    <= shamt_in;
            op_ctr <= ALUctr;
        end else if (state == SHIFT) begin
            shreg <= shreg_nx;
            cnt   <= cnt - 5'd1;
        end
    end
`else
    assign start_serial = 1'b0;
    assign last_step    = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = start_serial ? SHIFT : DONE;
            SHIFT:   if (last_step) state_nx = DONE;
            DONE:    if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            result <= '0;
            zero   <= 1'b0;
            less   <= 1'b0;
        end else if (accept) begin
            less <= less_in;
            if (!start_serial) begin
                result <= comb_res;
                zero   <= (comb_res == '0);
            end
        end
`ifdef ALU_SERIAL_SHIFT_EN
        else if (state == SHIFT && last_step) begin
            result <= shreg_nx;
            zero   <= (shreg_nx == '0);
        end
`endif
    end

endmodule
